// File: rtl/me_batch_ctrl.sv
// Batch controller: walks a motion-estimation engine over host_num_mb macroblocks
// and reports the minimum SAD with its vector and index. Optional per-index result log: RESULT_LOG_EN.
module me_batch_ctrl #(
    parameter int unsigned NMB_W  = 4,
    parameter int unsigned SAD_W  = 16,
    parameter int unsigned MVEC_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_req,
    input  logic [NMB_W-1:0]  host_num_mb,
    output logic              host_ack,
    output logic [SAD_W-1:0]  host_best_sad,
    output logic [MVEC_W-1:0] host_best_mvec,
    output logic [NMB_W-1:0]  host_best_idx,
    output logic              busy,
    output logic [NMB_W-1:0]  mb_idx,
    output logic              me_req,
    input  logic              me_ack,
    input  logic [SAD_W-1:0]  me_min_sad,
    input  logic [MVEC_W-1:0] me_min_mvec
`ifdef RESULT_LOG_EN
    ,
    input  logic [NMB_W-1:0]  log_raddr,
    output logic [SAD_W-1:0]  log_sad,
    output logic [MVEC_W-1:0] log_mvec
`endif
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENG_REQ = 3'd1,
        S_CAPTURE = 3'd2,
        S_ENG_REL = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_me_req;
    logic               r_host_ack;
    logic               r_busy;
    logic               w_me_req_nxt;
    logic               w_host_ack_nxt;
    logic               w_busy_nxt;
    logic               r_armed;
    logic [NMB_W-1:0]   r_num_mb;
    logic [NMB_W-1:0]   r_mb_idx;
    logic [SAD_W-1:0]   r_best_sad;
    logic [MVEC_W-1:0]  r_best_mvec;
    logic [NMB_W-1:0]   r_best_idx;
    logic               w_start;
    logic               w_last;
    logic               w_better;

    // A batch may only start once host_req has been seen low since reset or the last start,
    // so a request left high across a reset does not relaunch the engine.
    assign w_start  = (r_state == S_IDLE) && host_req && !me_ack && r_armed;
    // Count of zero wraps to all-ones, so the last index is 2^NMB_W - 1.
    assign w_last   = (r_mb_idx == NMB_W'(r_num_mb - 1'b1));
    assign w_better = (r_mb_idx == '0) || (me_min_sad < r_best_sad);

    // State register; control outputs are registered from the next-state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_me_req   <= 1'b0;
            r_host_ack <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_me_req   <= w_me_req_nxt;
            r_host_ack <= w_host_ack_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_start) w_state_nxt = S_ENG_REQ;
            S_ENG_REQ: if (me_ack) w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_ENG_REL;
            S_ENG_REL: if (!me_ack) w_state_nxt = w_last ? S_DONE : S_ENG_REQ;
            S_DONE:    if (!host_req) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode of the upcoming state.
    always_comb begin
        w_me_req_nxt   = 1'b0;
        w_host_ack_nxt = 1'b0;
        w_busy_nxt     = 1'b0;
        if (w_state_nxt == S_ENG_REQ) w_me_req_nxt = 1'b1;
        if (w_state_nxt == S_DONE)    w_host_ack_nxt = 1'b1;
        if (w_state_nxt != S_IDLE)    w_busy_nxt = 1'b1;
    end

    // Batch bookkeeping and best-result tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed     <= 1'b0;
            r_num_mb    <= '0;
            r_mb_idx    <= '0;
            r_best_sad  <= '0;
            r_best_mvec <= '0;
            r_best_idx  <= '0;
        end else begin
            if (w_start) begin
                r_armed  <= 1'b0;
                r_num_mb <= host_num_mb;
                r_mb_idx <= '0;
            end else if (!host_req) begin
                r_armed  <= 1'b1;
            end
            if ((r_state == S_ENG_REL) && !me_ack && !w_last) begin
                r_mb_idx <= NMB_W'(r_mb_idx + 1'b1);
            end
            if ((r_state == S_CAPTURE) && w_better) begin
                r_best_sad  <= me_min_sad;
                r_best_mvec <= me_min_mvec;
                r_best_idx  <= r_mb_idx;
            end
        end
    end

`ifdef RESULT_LOG_EN
    localparam int unsigned LOG_DEPTH = 1 << NMB_W;
    localparam int unsigned LOG_W     = SAD_W + MVEC_W;

    logic [LOG_W-1:0] r_log_mem [LOG_DEPTH];
    logic [LOG_W-1:0] r_log_rd;

    // Result RAM: no reset, one-cycle registered read.
    always_ff @(posedge clk) begin
        if (r_state == S_CAPTURE) begin
            r_log_mem[r_mb_idx] <= {me_min_sad, me_min_mvec};
        end
        r_log_rd <= r_log_mem[log_raddr];
    end

    assign log_sad  = r_log_rd[LOG_W-1:MVEC_W];
    assign log_mvec = r_log_rd[MVEC_W-1:0];
`endif

    assign me_req         = r_me_req;
    assign host_ack       = r_host_ack;
    assign busy           = r_busy;
    assign mb_idx         = r_mb_idx;
    assign host_best_sad  = r_best_sad;
    assign host_best_mvec = r_best_mvec;
    assign host_best_idx  = r_best_idx;

endmodule
